// File: rtl/lut_wvf_pkg.sv
// Shared definitions for the LUT waveform generator and monitor: FSM encoding and default widths.
// No logic, so no latency and no backpressure.
package lut_wvf_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int DEF_BITWIDTH  = 16;
  localparam int DEF_CNT_WIDTH = 16;
endpackage

// File: rtl/lut_wvf_minmax.sv
// Running min/max over one period; the first sample after clr loads both extremes directly.
// cur_min/cur_max already include a sample presented this cycle; it has no backpressure.
module lut_wvf_minmax
  import lut_wvf_pkg::*;
#(
  parameter int BITWIDTH = DEF_BITWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                smp_vld,
  input  logic [BITWIDTH-1:0] smp,
  output logic [BITWIDTH-1:0] cur_min,
  output logic [BITWIDTH-1:0] cur_max
);
  logic [BITWIDTH-1:0] min_q, min_d, max_q, max_d;
  logic                first_q, first_d;

  always_comb begin
    cur_min = min_q;
    cur_max = max_q;
    if (smp_vld) begin
      if (first_q || (smp <= min_q)) cur_min = smp;
      if (first_q || (smp >= max_q)) cur_max = smp;
    end
    // clr wins over the update; the caller samples cur_* in the same cycle
    min_d   = clr ? '1   : cur_min;
    max_d   = clr ? '0   : cur_max;
    first_d = clr ? 1'b1 : (first_q & ~smp_vld);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_q   <= '1;
      max_q   <= '0;
      first_q <= 1'b1;
    end else begin
      min_q   <= min_d;
      max_q   <= max_d;
      first_q <= first_d;
    end
  end
endmodule

// File: rtl/lut_wvf_monitor.sv
// Measures each waveform period (samples, cycles, min, max) and flags length/timeout errors.
// Result regs update one cycle after the end sample; input is a pure strobe stream, no backpressure.
module lut_wvf_monitor
  import lut_wvf_pkg::*;
#(
  parameter int BITWIDTH    = DEF_BITWIDTH,
  parameter int LUT_SIZE    = 64,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 CLK_SYS,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 DIN_VLD,
  input  logic [BITWIDTH-1:0]  DIN,
  input  logic                 DIN_END,
  output logic                 SYNC_DONE,
  output logic                 RESULT_VLD,
  output logic [CNT_WIDTH-1:0] SMP_CNT,
  output logic [CNT_WIDTH-1:0] PERIOD_CYC,
  output logic [BITWIDTH-1:0]  VAL_MIN,
  output logic [BITWIDTH-1:0]  VAL_MAX,
  output logic [7:0]           NUM_PERIODS,
  output logic                 ERR_LEN,
  output logic                 ERR_TMO
);
  localparam logic [CNT_WIDTH-1:0] LUT_SIZE_C = CNT_WIDTH'(LUT_SIZE);
  localparam logic [CNT_WIDTH-1:0] TMO_C      = CNT_WIDTH'(TIMEOUT_CYC);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] smp_q, smp_d, cyc_q, cyc_d;
  logic [CNT_WIDTH-1:0] smp_cnt_q, smp_cnt_d, period_cyc_q, period_cyc_d;
  logic [BITWIDTH-1:0]  val_min_q, val_min_d, val_max_q, val_max_d;
  logic [7:0]           num_q, num_d;
  logic                 err_len_q, err_len_d, err_tmo_q, err_tmo_d;
  logic                 result_vld_q, result_vld_d;

  logic                 run_act, end_smp, mm_clr;
  logic [CNT_WIDTH-1:0] smp_inc, cyc_inc;
  logic [BITWIDTH-1:0]  cur_min, cur_max;

  assign run_act = EN && (state_q == ST_RUN);
  assign end_smp = DIN_VLD && DIN_END;
  assign smp_inc = (&smp_q) ? smp_q : smp_q + 1'b1;
  assign cyc_inc = (&cyc_q) ? cyc_q : cyc_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    smp_d        = '0;
    cyc_d        = '0;
    mm_clr       = 1'b1;
    smp_cnt_d    = smp_cnt_q;
    period_cyc_d = period_cyc_q;
    val_min_d    = val_min_q;
    val_max_d    = val_max_q;
    num_d        = num_q;
    err_len_d    = err_len_q;
    err_tmo_d    = err_tmo_q;
    result_vld_d = 1'b0;
    if (!EN) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_SYNC;
        ST_SYNC: if (end_smp) state_d = ST_RUN;
        ST_RUN: begin
          mm_clr = 1'b0;
          cyc_d  = cyc_inc;
          smp_d  = DIN_VLD ? smp_inc : smp_q;
          // an end sample landing on the timeout cycle still completes the period
          if (end_smp) begin
            smp_cnt_d    = smp_inc;
            period_cyc_d = cyc_inc;
            val_min_d    = cur_min;
            val_max_d    = cur_max;
            num_d        = num_q + 8'd1;
            result_vld_d = 1'b1;
            if (smp_inc != LUT_SIZE_C) err_len_d = 1'b1;
            smp_d  = '0;
            cyc_d  = '0;
            mm_clr = 1'b1;
          end else if (cyc_inc >= TMO_C) begin
            err_tmo_d = 1'b1;
            state_d   = ST_SYNC;
            smp_d     = '0;
            cyc_d     = '0;
            mm_clr    = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_SYS) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      smp_q        <= '0;
      cyc_q        <= '0;
      smp_cnt_q    <= '0;
      period_cyc_q <= '0;
      val_min_q    <= '0;
      val_max_q    <= '0;
      num_q        <= '0;
      err_len_q    <= 1'b0;
      err_tmo_q    <= 1'b0;
      result_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      smp_q        <= smp_d;
      cyc_q        <= cyc_d;
      smp_cnt_q    <= smp_cnt_d;
      period_cyc_q <= period_cyc_d;
      val_min_q    <= val_min_d;
      val_max_q    <= val_max_d;
      num_q        <= num_d;
      err_len_q    <= err_len_d;
      err_tmo_q    <= err_tmo_d;
      result_vld_q <= result_vld_d;
    end
  end

  lut_wvf_minmax #(.BITWIDTH(BITWIDTH)) u_minmax (
    .clk     (CLK_SYS),
    .rst     (RST),
    .clr     (mm_clr),
    .smp_vld (DIN_VLD && run_act),
    .smp     (DIN),
    .cur_min (cur_min),
    .cur_max (cur_max)
  );

  assign SYNC_DONE   = (state_q == ST_RUN);
  assign RESULT_VLD  = result_vld_q;
  assign SMP_CNT     = smp_cnt_q;
  assign PERIOD_CYC  = period_cyc_q;
  assign VAL_MIN     = val_min_q;
  assign VAL_MAX     = val_max_q;
  assign NUM_PERIODS = num_q;
  assign ERR_LEN     = err_len_q;
  assign ERR_TMO     = err_tmo_q;
endmodule
